// File: rtl/sipo_byte_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_byte_assembler_pkg
// Purpose  : Shared state encoding and default word width for the SIPO
//            byte assembler and its output slot.
// Revision : 1.0  initial release
// ============================================================================
package sipo_byte_assembler_pkg;

  localparam int unsigned SIPO_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } sipo_state_e;

endpackage
`default_nettype wire

// File: rtl/sipo_byte_assembler_out_slot.sv
`default_nettype none
// ============================================================================
// Module   : sipo_byte_assembler_out_slot
// Purpose  : One-entry valid/ready holding register for assembled words.
//            A push is accepted when the slot is empty or being popped on the
//            same edge; otherwise the pushed word is dropped and overrun
//            pulses for one cycle. q is never cleared by a pop.
// Revision : 1.0  initial release
// ============================================================================
module sipo_byte_assembler_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             q_ready_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;
  logic             w_free;

  // Slot can take a new word if empty or if the held word leaves this edge
  assign w_free = !valid_q || q_ready_i;

  // Slot register: push wins over pop, drops a word when full and stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push_i && !w_free;
      if (push_i && w_free) begin
        data_q  <= push_data_i;
        valid_q <= 1'b1;
      end else if (valid_q && q_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign q_o       = data_q;
  assign q_valid_o = valid_q;
  assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: rtl/sipo_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : sipo_byte_assembler
// Purpose  : Serial-in/parallel-out assembler. Collects framed serial bits
//            into WIDTH-bit words and hands them to a one-entry output slot.
//            Mid-word frame_start flags frame_err and restarts the word.
// Options  : PARITY_CHECK_EN - adds an even-parity bit after each word;
//            mismatching words are discarded with a parity_err pulse.
// Revision : 1.0  initial release
// ============================================================================
module sipo_byte_assembler
  import sipo_byte_assembler_pkg::*;
#(
  parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overrun,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sipo_state_e      state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] w_first;
  logic [WIDTH-1:0] w_shifted;
  logic             w_push;
  logic [WIDTH-1:0] w_push_data;
`ifdef PARITY_CHECK_EN
  logic             parity_err_q, parity_err_d;
`endif

  // Bit placement: first bit ends up at q[WIDTH-1] or q[0] after WIDTH shifts
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first   = {{(WIDTH-1){1'b0}}, sin};
      assign w_shifted = {shift_q[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign w_first   = {sin, {(WIDTH-1){1'b0}}};
      assign w_shifted = {sin, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // State, counter, shift register and error-pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      frame_err_q  <= frame_err_d;
`ifdef PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic: framing, shifting, completion and parity decision
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    frame_err_d  = 1'b0;
    w_push       = 1'b0;
    w_push_data  = w_shifted;
`ifdef PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sin_valid && frame_start) begin
          shift_d   = w_first;
          bit_cnt_d = CW'(1);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sin_valid) begin
          if (frame_start) begin
            frame_err_d = 1'b1;
            shift_d     = w_first;
            bit_cnt_d   = CW'(1);
          end else begin
            shift_d = w_shifted;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
              state_d   = ST_PARITY;
`else
              state_d   = ST_IDLE;
              w_push    = 1'b1;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
        end
      end
`ifdef PARITY_CHECK_EN
      ST_PARITY: begin
        if (sin_valid) begin
          if (frame_start) begin
            frame_err_d = 1'b1;
            shift_d     = w_first;
            bit_cnt_d   = CW'(1);
            state_d     = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
            // Even parity: the parity bit equals the XOR of the data bits
            if (sin == ^shift_q) begin
              w_push      = 1'b1;
              w_push_data = shift_q;
            end else begin
              parity_err_d = 1'b1;
            end
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  sipo_byte_assembler_out_slot #(
    .WIDTH(WIDTH)
  ) u_out_slot (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .q_ready_i   (q_ready),
    .q_o         (q),
    .q_valid_o   (q_valid),
    .overrun_o   (overrun)
  );

  assign frame_err = frame_err_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sipo_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_byte_assembler
// Purpose  : Self-checking bench for sipo_byte_assembler (WIDTH=8, MSB first)
//            using a directed vector table, hand-written corner sequences and
//            randomized traffic compared against a queue-based word model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sipo_byte_assembler;

  localparam int W    = 8;
  localparam bit MSBF = 1'b1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sin, sin_valid, frame_start, q_ready;
  logic [W-1:0] q;
  logic         q_valid, overrun, frame_err, parity_err;

  always #5 clk = ~clk;

  sipo_byte_assembler #(.WIDTH(W), .MSB_FIRST(MSBF)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .frame_start (frame_start),
    .q           (q),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  // Downstream PIPO register loads q whenever a word is accepted
  logic [W-1:0] pipo_q;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pipo_q <= '0;
    else if (q_valid && q_ready) pipo_q <= q;
  end

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (word level, queue based) -------------
  bit           mq[$];
  bit           m_in, m_par;
  logic [W-1:0] m_word, exp_q;
  bit           exp_v, exp_ovr, exp_fe, exp_pe;

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (MSBF) w[W-1-i] = mq[i];
      else      w[i]     = mq[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_in = 0; m_par = 0; m_word = '0;
    exp_q = '0; exp_v = 0; exp_ovr = 0; exp_fe = 0; exp_pe = 0;
  endtask

  task automatic model_step(input bit s, input bit v, input bit fs, input bit rdy);
    bit push;
    push = 0; exp_ovr = 0; exp_fe = 0; exp_pe = 0;
    if (v) begin
      if (fs) begin
        exp_fe = m_in || m_par;
        mq.delete();
        mq.push_back(s);
        m_in = 1; m_par = 0;
      end else if (m_par) begin
        m_par = 0;
        if ((($countones(m_word) + int'(s)) % 2) == 0) push = 1;
        else exp_pe = 1;
      end else if (m_in) begin
        mq.push_back(s);
        if (mq.size() == W) begin
          m_word = pack_bits();
          mq.delete();
          m_in = 0;
`ifdef PARITY_CHECK_EN
          m_par = 1;
`else
          push = 1;
`endif
        end
      end
    end
    if (push) begin
      if (!exp_v || rdy) begin exp_q = m_word; exp_v = 1; end
      else exp_ovr = 1;
    end else if (exp_v && rdy) begin
      exp_v = 0;
    end
  endtask

  // ---------------- stimulus helpers --------------------------------------
  task automatic cycle(input bit s, input bit v, input bit fs, input bit rdy);
    sin = s; sin_valid = v; frame_start = fs; q_ready = rdy;
    @(posedge clk);
    #1;
    model_step(s, v, fs, rdy);
  endtask

  task automatic chk_model(input string name);
    check(name, {4'h0, q, q_valid, overrun, frame_err, parity_err},
                {4'h0, exp_q, exp_v, exp_ovr, exp_fe, exp_pe});
  endtask

  task automatic mcycle(input string name, input bit s, input bit v, input bit fs, input bit rdy);
    cycle(s, v, fs, rdy);
    chk_model(name);
  endtask

  // Sends one framed word; rdy_last is q_ready on the completing edge
  task automatic send_word(input logic [W-1:0] word, input bit rdy, input bit rdy_last,
                           input int maxgap, input bit par_ok);
    bit b;
    for (int i = 0; i < W; i++) begin
      repeat ($urandom_range(0, maxgap)) mcycle("gap", 1'($urandom), 1'b0, 1'($urandom), rdy);
      b = MSBF ? word[W-1-i] : word[i];
`ifdef PARITY_CHECK_EN
      mcycle("data", b, 1'b1, i == 0, rdy);
`else
      mcycle("data", b, 1'b1, i == 0, (i == W-1) ? rdy_last : rdy);
`endif
    end
`ifdef PARITY_CHECK_EN
    repeat ($urandom_range(0, maxgap)) mcycle("gap", 1'($urandom), 1'b0, 1'b0, rdy);
    mcycle("parity", (^word) ^ !par_ok, 1'b1, 1'b0, rdy_last);
`else
    if (par_ok) begin end
`endif
  endtask

  task automatic do_reset();
    sin = 0; sin_valid = 0; frame_start = 0; q_ready = 0;
    #2 reset_n = 1'b0;
    #1 check("reset_outs", {4'h0, q, q_valid, overrun, frame_err, parity_err}, 16'h0000);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    bit           s, v, fs, rdy;
    logic [W-1:0] eq;
    bit           ev, eo, ef;
  } vec_t;
  vec_t tbl[$];
  int   pipo_idx;

  task automatic add(input bit s, input bit v, input bit fs, input bit rdy,
                     input logic [W-1:0] eq, input bit ev, input bit eo, input bit ef);
    vec_t r;
    r.s = s; r.v = v; r.fs = fs; r.rdy = rdy; r.eq = eq; r.ev = ev; r.eo = eo; r.ef = ef;
    tbl.push_back(r);
  endtask

  initial begin
    bit a5_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bit ab_bits[4] = '{1, 1, 1, 1};
    bit s5a[7]     = '{1, 0, 1, 1, 0, 1, 0};

    // Bits without frame_start in IDLE are ignored
    add(1, 1, 0, 1, 8'h00, 0, 0, 0);
    add(1, 1, 0, 1, 8'h00, 0, 0, 0);
    // A5, MSB first, consumer always ready
    for (int i = 0; i < 7; i++) add(a5_bits[i], 1, i == 0, 1, 8'h00, 0, 0, 0);
    add(a5_bits[7], 1, 0, 1, 8'hA5, 1, 0, 0);
    pipo_idx = tbl.size();
    add(0, 0, 0, 1, 8'hA5, 0, 0, 0);
    // Abort after 5 bits, then 5A
    add(0, 1, 1, 1, 8'hA5, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(ab_bits[i], 1, 0, 1, 8'hA5, 0, 0, 0);
    add(0, 1, 1, 1, 8'hA5, 0, 0, 1);
    for (int i = 0; i < 6; i++) add(s5a[i], 1, 0, 1, 8'hA5, 0, 0, 0);
    add(s5a[6], 1, 0, 1, 8'h5A, 1, 0, 0);
    add(0, 0, 0, 1, 8'h5A, 0, 0, 0);

    model_reset();
    reset_n = 1'b0;
    sin = 0; sin_valid = 0; frame_start = 0; q_ready = 0;
    repeat (2) @(posedge clk);
    #1 check("reset_init", {4'h0, q, q_valid, overrun, frame_err, parity_err}, 16'h0000);
    reset_n = 1'b1;

`ifndef PARITY_CHECK_EN
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].s, tbl[i].v, tbl[i].fs, tbl[i].rdy);
      check($sformatf("table[%0d]", i), {4'h0, q, q_valid, overrun, frame_err, parity_err},
            {4'h0, tbl[i].eq, tbl[i].ev, tbl[i].eo, tbl[i].ef, 1'b0});
      if (i == pipo_idx) check("pipo_load", {8'h00, pipo_q}, 16'h00A5);
    end
`endif

    // Back-to-back words at full rate
    do_reset();
    send_word(8'h3C, 1, 1, 0, 1);
    check("b2b_first", {7'h0, q, q_valid}, {7'h0, 8'h3C, 1'b1});
    send_word(8'hC3, 1, 1, 0, 1);
    check("b2b_second", {6'h0, q, q_valid, overrun}, {6'h0, 8'hC3, 1'b1, 1'b0});
    mcycle("b2b_drain", 0, 0, 0, 1);

    // Stalled consumer: second word overruns, first is kept
    send_word(8'h11, 0, 0, 0, 1);
    send_word(8'h22, 0, 0, 0, 1);
    check("ovr_hold", {6'h0, q, q_valid, overrun}, {6'h0, 8'h11, 1'b1, 1'b1});
    mcycle("ovr_after", 0, 0, 0, 0);
    mcycle("ovr_drain", 0, 0, 0, 1);
    // Pop and push on the same edge: no overrun
    send_word(8'h11, 0, 0, 0, 1);
    send_word(8'h22, 0, 1, 0, 1);
    check("pop_push", {6'h0, q, q_valid, overrun}, {6'h0, 8'h22, 1'b1, 1'b0});
    mcycle("pp_drain", 0, 0, 0, 1);

    // Reset mid-word with a held word discards everything silently
    send_word(8'h11, 0, 0, 0, 1);
    mcycle("mid1", 1, 1, 1, 0);
    mcycle("mid2", 0, 1, 0, 0);
    do_reset();
    mcycle("post_rst_ign1", 1, 1, 0, 1);
    mcycle("post_rst_ign2", 1, 1, 0, 1);

`ifdef PARITY_CHECK_EN
    send_word(8'h07, 1, 1, 0, 1);
    check("par_ok", {7'h0, q, q_valid}, {7'h0, 8'h07, 1'b1});
    mcycle("par_drain", 0, 0, 0, 1);
    send_word(8'h07, 1, 1, 0, 0);
    check("par_bad", {6'h0, q_valid, parity_err}, {6'h0, 8'h00, 1'b0, 1'b1});
    for (int i = 0; i < 10; i++) send_word(8'h07, 1, 1, 3, i[0]);
`endif

    // Random framed words with gaps and random readiness
    for (int i = 0; i < 40; i++)
      send_word(8'($urandom), 1'($urandom), 1'($urandom), 3, ($urandom % 4) != 0);

    // Fully random traffic including aborts
    for (int i = 0; i < 600; i++)
      mcycle("rand", 1'($urandom), ($urandom % 4) != 0, ($urandom % 10) == 0, 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  // Safety net against a stuck simulation
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
